// File: rtl/pix_median_filter_mc.sv
// Multi-channel 3x3 raster filter: median/min/max/bypass per frame,
// shared line buffers, border pass-through and self-flush of last rows.
module pix_median_filter_mc #(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             pi_flag,
  input  logic             pi_sof,
  input  logic [CH*DW-1:0] pi_data,
  output logic             pi_ready,
  input  logic [1:0]       mode,
  output logic             po_flag,
  output logic [CH*DW-1:0] po_data,
  output logic             po_eof
);

  localparam int PW = CH * DW;
  localparam int N  = IMG_W * IMG_H;
  localparam int NW = $clog2(N + 1);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int FW = $clog2(IMG_W + 1);

  localparam logic [NW-1:0] N_LAST  = NW'(N - 1);
  localparam logic [NW-1:0] N_PRIME = NW'(IMG_W + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(IMG_H - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(IMG_W);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [DW-1:0] lo;
    logic [DW-1:0] md;
    logic [DW-1:0] hi;
  } col_t;

  typedef struct packed {
    logic       v;
    logic       b;
    logic       e;
    logic [1:0] m;
  } meta_t;

  function automatic logic [DW-1:0] mn2(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] mx2(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    return (a < b) ? b : a;
  endfunction

  function automatic logic [DW-1:0] md3(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [DW-1:0] c
  );
    return mx2(mn2(a, b), mn2(mx2(a, b), c));
  endfunction

  function automatic col_t sort3(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [DW-1:0] c
  );
    col_t r;
    r.lo = mn2(mn2(a, b), c);
    r.md = md3(a, b, c);
    r.hi = mx2(mx2(a, b), c);
    return r;
  endfunction

  state_t        state;
  logic [NW-1:0] n;
  logic [CW-1:0] c;
  logic [CW-1:0] ocol;
  logic [RW-1:0] orow;
  logic [FW-1:0] fc;
  logic [1:0]    fmode;

  logic          acc;
  logic          start;
  logic          fl;
  logic          adv;
  logic          emit;
  logic          last;
  logic          brd;
  logic          eofc;
  logic [NW-1:0] idx;
  logic [CW-1:0] wcol;

  always_comb begin
    acc   = pi_flag & pi_ready;
    start = acc & ((state == IDLE) | pi_sof);
    idx   = start ? '0 : n;
    wcol  = start ? '0 : c;
    fl    = (state == FLUSH);
    adv   = acc | fl;
    emit  = fl | (acc & (idx >= N_PRIME));
    last  = acc & (idx == N_LAST);
    brd   = (orow == '0) | (orow == R_LAST) |
            (ocol == '0) | (ocol == C_LAST);
    eofc  = fl & (orow == R_LAST) & (ocol == C_LAST);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pi_ready <= 1'b0;
      n        <= '0;
      c        <= '0;
      ocol     <= '0;
      orow     <= '0;
      fc       <= '0;
      fmode    <= '0;
    end else begin
      pi_ready <= 1'b1;
      if (adv)
        c <= (wcol == C_LAST) ? '0 : wcol + 1'b1;
      if (acc)
        n <= idx + 1'b1;
      if (start) begin
        fmode <= mode;
        ocol  <= '0;
        orow  <= '0;
      end else if (emit) begin
        if (ocol == C_LAST) begin
          ocol <= '0;
          orow <= orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (acc)
            state <= RUN;
        end
        RUN: begin
          if (last) begin
            state    <= FLUSH;
            fc       <= '0;
            pi_ready <= 1'b0;
          end
        end
        FLUSH: begin
          if (fc == F_LAST) begin
            state <= IDLE;
          end else begin
            fc       <= fc + 1'b1;
            pi_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // lb0 holds the previous line, lb1 the one before; read-before-write
  logic [PW-1:0] lb0 [IMG_W];
  logic [PW-1:0] lb1 [IMG_W];
  logic [PW-1:0] r0;
  logic [PW-1:0] r1;
  logic [PW-1:0] px;

  assign r0 = lb0[wcol];
  assign r1 = lb1[wcol];
  assign px = acc ? pi_data : '0;

  always_ff @(posedge sclk) begin
    if (adv) begin
      lb0[wcol] <= px;
      lb1[wcol] <= r0;
    end
  end

  col_t          cs [3][CH];
  logic [PW-1:0] ct0;
  logic [PW-1:0] ct1;
  meta_t         m1;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cs[0][i] <= '0;
        cs[1][i] <= '0;
        cs[2][i] <= '0;
      end
      ct0 <= '0;
      ct1 <= '0;
      m1  <= '0;
    end else begin
      m1.v <= emit;
      m1.b <= brd;
      m1.e <= eofc;
      m1.m <= fmode;
      if (adv) begin
        for (int i = 0; i < CH; i++) begin
          cs[2][i] <= cs[1][i];
          cs[1][i] <= cs[0][i];
          cs[0][i] <= sort3(r1[i*DW +: DW],
                            r0[i*DW +: DW],
                            px[i*DW +: DW]);
        end
        ct1 <= ct0;
        ct0 <= r0;
      end
    end
  end

  logic [DW-1:0] s2_lo [CH];
  logic [DW-1:0] s2_md [CH];
  logic [DW-1:0] s2_hi [CH];
  logic [DW-1:0] s2_mn [CH];
  logic [DW-1:0] s2_mx [CH];
  logic [PW-1:0] ct2;
  meta_t         m2;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        s2_lo[i] <= '0;
        s2_md[i] <= '0;
        s2_hi[i] <= '0;
        s2_mn[i] <= '0;
        s2_mx[i] <= '0;
      end
      ct2 <= '0;
      m2  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        s2_lo[i] <= mx2(mx2(cs[0][i].lo, cs[1][i].lo), cs[2][i].lo);
        s2_md[i] <= md3(cs[0][i].md, cs[1][i].md, cs[2][i].md);
        s2_hi[i] <= mn2(mn2(cs[0][i].hi, cs[1][i].hi), cs[2][i].hi);
        s2_mn[i] <= mn2(mn2(cs[0][i].lo, cs[1][i].lo), cs[2][i].lo);
        s2_mx[i] <= mx2(mx2(cs[0][i].hi, cs[1][i].hi), cs[2][i].hi);
      end
      ct2 <= ct1;
      m2  <= m1;
    end
  end

  logic [DW-1:0] s3_md [CH];
  logic [DW-1:0] s3_mn [CH];
  logic [DW-1:0] s3_mx [CH];
  logic [PW-1:0] ct3;
  meta_t         m3;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        s3_md[i] <= '0;
        s3_mn[i] <= '0;
        s3_mx[i] <= '0;
      end
      ct3 <= '0;
      m3  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        s3_md[i] <= md3(s2_lo[i], s2_md[i], s2_hi[i]);
        s3_mn[i] <= s2_mn[i];
        s3_mx[i] <= s2_mx[i];
      end
      ct3 <= ct2;
      m3  <= m2;
    end
  end

  logic [1:0] sel;

  assign sel = m3.b ? 2'd0 : m3.m;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      po_flag <= 1'b0;
      po_eof  <= 1'b0;
      po_data <= '0;
    end else begin
      po_flag <= m3.v;
      po_eof  <= m3.v & m3.e;
      if (m3.v) begin
        for (int i = 0; i < CH; i++) begin
          unique case (sel)
            2'd1:    po_data[i*DW +: DW] <= s3_md[i];
            2'd2:    po_data[i*DW +: DW] <= s3_mn[i];
            2'd3:    po_data[i*DW +: DW] <= s3_mx[i];
            default: po_data[i*DW +: DW] <= ct3[i*DW +: DW];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pix_median_filter_mc.sv
// Directed bench for pix_median_filter_mc on an 8x6 RGB frame;
// a reference 3x3 model fills a scoreboard popped on each po_flag.
module tb_pix_median_filter_mc;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int NP = W * H;

  typedef struct packed {
    logic [23:0] d;
    logic        e;
  } exp_t;

  logic        sclk;
  logic        rst_n;
  logic        pi_flag;
  logic        pi_sof;
  logic [23:0] pi_data;
  logic        pi_ready;
  logic [1:0]  mode;
  logic        po_flag;
  logic [23:0] po_data;
  logic        po_eof;

  logic [23:0] img [NP];
  exp_t        q [$];
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;

  pix_median_filter_mc #(
    .CH(3), .DW(8), .IMG_W(W), .IMG_H(H)
  ) dut (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .pi_flag (pi_flag),
    .pi_sof  (pi_sof),
    .pi_data (pi_data),
    .pi_ready(pi_ready),
    .mode    (mode),
    .po_flag (po_flag),
    .po_data (po_data),
    .po_eof  (po_eof)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sort the nine window values and pick by mode.
  task automatic model_push(input int m, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      int          r;
      int          c;
      int          v [9];
      int          t;
      logic [23:0] p;
      exp_t        e;
      r   = k / W;
      c   = k % W;
      e.e = (k == NP - 1);
      e.d = img[k];
      if (m != 0 && r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
        for (int ch = 0; ch < 3; ch++) begin
          for (int j = 0; j < 9; j++) begin
            p    = img[(r + j / 3 - 1) * W + c + j % 3 - 1];
            v[j] = int'(p[ch*8 +: 8]);
          end
          for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8 - a; b++)
              if (v[b] > v[b+1]) begin
                t = v[b]; v[b] = v[b+1]; v[b+1] = t;
              end
          if (m == 1)      e.d[ch*8 +: 8] = 8'(v[4]);
          else if (m == 2) e.d[ch*8 +: 8] = 8'(v[0]);
          else             e.d[ch*8 +: 8] = 8'(v[8]);
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic send_pixels(input int cnt, input int m, input int gap);
    int b;
    for (int i = 0; i < cnt; i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        pi_flag = 1'b0;
        @(posedge sclk); #1;
      end
      pi_flag = 1'b1;
      pi_sof  = (i == 0);
      pi_data = img[i];
      if (i == 0) mode = 2'(m);
      b = 0;
      while (!pi_ready && b < 50) begin
        @(posedge sclk); #1;
        b++;
      end
      if (b == 50) chk("ready_timeout", 64'd0, 64'd1);
      @(posedge sclk); #1;
      mode = 2'(m) ^ 2'b11;
    end
    pi_flag = 1'b0;
    pi_sof  = 1'b0;
  endtask

  task automatic flush_and_drain();
    int low;
    int b;
    pi_flag = 1'b1;
    pi_sof  = 1'b0;
    pi_data = 24'hABCDEF;
    low = 0;
    while (!pi_ready && low < 100) begin
      low++;
      @(posedge sclk); #1;
    end
    pi_flag = 1'b0;
    chk("ready_low_cycles", 64'(low), 64'(W + 1));
    b = 0;
    while (q.size() != 0 && b < 100) begin
      @(posedge sclk); #1;
      b++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic run_frame(input int m, input int gap);
    model_push(m, NP);
    send_pixels(NP, m, gap);
    flush_and_drain();
  endtask

  always @(negedge sclk) begin
    if (rst_n && po_flag) begin
      if (q.size() == 0) begin
        chk("extra_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("po_data", 64'(po_data), 64'(e.d));
        chk("po_eof", 64'(po_eof), 64'(e.e));
      end
    end
  end

  initial begin
    logic [23:0] rnd [NP];
    rst_n   = 1'b0;
    pi_flag = 1'b0;
    pi_sof  = 1'b0;
    pi_data = '0;
    mode    = '0;
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_po_flag", 64'(po_flag), 64'd0);
    chk("rst_po_data", 64'(po_data), 64'd0);
    chk("rst_po_eof", 64'(po_eof), 64'd0);
    chk("rst_ready", 64'(pi_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", 64'(pi_ready), 64'd0);
    @(posedge sclk); #1;
    chk("ready_first_edge", 64'(pi_ready), 64'd1);

    for (int i = 0; i < NP; i++) img[i] = {3{8'(i)}};
    run_frame(0, 0);

    for (int i = 0; i < NP; i++) img[i] = 24'h404040;
    img[2*W+3] = 24'h40FF40;
    run_frame(1, 0);

    for (int i = 0; i < NP; i++)
      img[i] = (((i / W) + (i % W)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
    run_frame(2, 0);
    run_frame(3, 0);

    for (int i = 0; i < NP; i++) rnd[i] = 24'($urandom);
    for (int i = 0; i < NP; i++) img[i] = rnd[i];
    run_frame(1, 0);
    run_frame(1, 30);

    for (int i = 0; i < NP; i++) img[i] = 24'($urandom);
    model_push(1, 11);
    send_pixels(20, 1, 0);
    for (int i = 0; i < NP; i++) img[i] = 24'($urandom);
    run_frame(1, 0);

    for (int i = 0; i < NP; i++) img[i] = 24'($urandom);
    model_push(2, 21);
    send_pixels(30, 2, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_po_flag", 64'(po_flag), 64'd0);
    chk("midrst_po_data", 64'(po_data), 64'd0);
    chk("midrst_po_eof", 64'(po_eof), 64'd0);
    chk("midrst_ready", 64'(pi_ready), 64'd0);
    q.delete();
    repeat (2) @(posedge sclk);
    #3;
    rst_n = 1'b1;
    @(posedge sclk); #1;
    chk("ready_after_midrst", 64'(pi_ready), 64'd1);

    for (int i = 0; i < NP; i++) img[i] = 24'($urandom);
    run_frame(3, 20);

    repeat (5) @(posedge sclk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pix_median_filter_mc.md
# pix_median_filter_mc

Parametrised multi-channel 3x3 raster filter that replaces the fixed three-instance 8-bit RGB median wrapper with a single block. It holds shared line buffers for `CH` channels of `DW` bits, and selects median, min, max or bypass per frame. It handles border pixels deterministically and self-flushes the final rows, with a ready handshake. It sits in the pixel pipeline between the capture/colour stage and the downstream display/process stage.

## Interface
- `CH`, 3, number of channels packed in one pixel word.
- `DW`, 8, bits per channel (unsigned).
- `IMG_W`, 640, pixels per line; must be ≥ 4.
- `IMG_H`, 480, lines per frame; must be ≥ 3.

- `sclk`  in  1  single clock, all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `pi_flag`  in  1  input pixel valid.
- `pi_sof`  in  1  qualifies the current input pixel as the first of a frame.
- `pi_data`  in  CH*DW  input pixel; channel i at bits [i*DW +: DW].
- `pi_ready`  out  1  block accepts a pixel when pi_flag & pi_ready.
- `mode`  in  2  0 = bypass, 1 = median, 2 = min, 3 = max.
- `po_flag`  out  1  output pixel valid; one-cycle pulse per pixel, no backpressure.
- `po_data`  out  CH*DW  filtered pixel, same packing as pi_data.
- `po_eof`  out  1  high with po_flag on the last pixel (index N-1) of a frame.

## Operation
- N = IMG_W*IMG_H. Raster index n counts accepted pixels; col = n mod IMG_W, row = n / IMG_W.
- Storage is two line buffers of depth IMG_W and width CH*DW, plus a 3x3 window register per channel. All channels use the same window position and mode.
- Frame start:
  - An accepted pixel with pi_sof = 1 is index 0 and clears the counters.
  - `mode` is sampled on that pixel only and held for the whole frame; later changes to `mode` are ignored.
  - An accepted pixel without any prior sof since reset is also treated as index 0.
- States:
  - IDLE (pi_ready = 1): first accept goes to RUN with n = 1.
  - RUN (pi_ready = 1): accept pixels. When n = N-1 is accepted, go to FLUSH.
  - FLUSH (pi_ready = 0): IMG_W+1 internal cycles, one synthetic window advance per cycle, then IDLE.
- Output ordering:
  - Output pixel k is produced when input k+IMG_W+1 is accepted, for k ≤ N-IMG_W-2.
  - The remaining IMG_W+1 outputs (k = N-IMG_W-1 .. N-1) are produced by the FLUSH cycles, in order.
  - Exactly N outputs are produced per completed frame, in raster order.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1): output equals the centre input pixel unchanged, in every mode. Lines never wrap into the window of a border column.
- Interior pixels, per channel, operate on the 9 window values:
  - median: 5th of 9.
  - min / max: minimum / maximum of 9.
  - bypass: centre value.
  - All compares are unsigned DW-bit; ties resolve to equal values, so no ordering ambiguity reaches the output.
- Pipeline:
  - s1: sort each window column into lo/mid/hi, and take column min/max.
  - s2: max of lo, median of mid, min of hi, and the running min/max.
  - s3: median of the three s2 results.
  - s4: mode/border mux into the registered outputs.
- Abort:
  - pi_sof accepted in RUN starts a new frame at index 0.
  - Outputs of the aborted frame not yet generated are dropped, and no FLUSH occurs for it.
  - Up to 4 results already in s1–s4 still emerge, with po_eof = 0.

## Timing
- Reset values: po_flag = 0, po_data = 0, po_eof = 0, pi_ready = 0 while rst_n is low, 1 from the first edge after release. State is IDLE, counters are 0, line buffer contents are don't-care.
- Latency is 4 cycles from the triggering event (the accept of pixel k+IMG_W+1, or the FLUSH cycle) to po_flag for pixel k.
- Throughput is one pixel per cycle. pi_flag gaps stall window advance only; nothing is dropped.
- FLUSH:
  - pi_ready goes low the cycle after pixel N-1 is accepted and stays low for exactly IMG_W+1 cycles.
  - pi_flag during FLUSH is ignored.
  - pi_ready returns high with IDLE.
- The last po_flag of a frame (with po_eof) occurs 4 cycles after the final FLUSH cycle.
- The pipeline tail of a frame may overlap the first accepts of the next frame; outputs stay in order.
- rst_n asserted mid-frame: all state and outputs return to reset values immediately, and in-flight pixels are lost.

## Test plan
- Bypass, IMG_W = 8, IMG_H = 6, CH = 3, ramp input pi_data = {n,n,n}:
  - 48 po_flag pulses with po_data = {k,k,k} for k = 0..47, in order.
  - po_eof only on k = 47.
  - pi_ready low for exactly 9 cycles.
- Median, flat frame of 0x40 with an impulse 0xFF at (row 2, col 3) on channel 1 only:
  - All outputs 0x40 in every channel.
  - The impulse sits on an interior pixel, so median removes it.
- Min and max, checkerboard 0x00/0xFF:
  - Interior outputs are all 0x00 (min) and all 0xFF (max).
  - Border outputs equal the input checkerboard value.
- Border, median mode, random data:
  - Rows 0 and 5 and cols 0 and 7 reproduce the input exactly.
  - Interior matches a software 3x3 median per channel.
- Handshake and stall:
  - Random pi_flag gaps (30% idle) give output identical to the gapless run.
  - pi_flag held high through FLUSH accepts nothing until pi_ready returns.
- Abort and reset:
  - pi_sof at n = 20, then a full frame: only ≤ 4 stale pulses, then the correct 48-pixel new frame.
  - rst_n low at n = 30: all outputs 0 within the same cycle, and the next frame is correct.
